// File: rtl/branch_pred_queue.sv
// In-order branch prediction tracking queue: records fetch predictions, resolves them
// oldest-first, feeds the predictor and redirects fetch on a mispredict. Optional stats: BPQ_STATS_EN.
module branch_pred_queue #(
  parameter int unsigned PCW      = 31,
  parameter int unsigned QAW      = 2,
  parameter int unsigned FALL_INC = 2
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           push_i,
  input  logic [PCW-1:0] push_pc_i,
  input  logic           push_taken_i,
  input  logic [PCW-1:0] push_target_i,
  output logic           full_o,
  output logic [QAW:0]   count_o,
  input  logic           resolve_i,
  input  logic           resolve_taken_i,
  input  logic [PCW-1:0] resolve_target_i,
  output logic           feedback_valid_o,
  output logic [PCW-1:0] feedback_pc_o,
  output logic           feedback_taken_o,
  output logic [PCW-1:0] feedback_target_o,
  output logic           mispredict_o,
  output logic [PCW-1:0] redirect_pc_o
`ifdef BPQ_STATS_EN
  ,
  output logic [15:0]    stat_branches_o,
  output logic [15:0]    stat_mispred_o
`endif
);

  localparam int unsigned DEPTH = 1 << QAW;
  localparam int unsigned PTRW  = QAW + 1;

  typedef struct packed {
    logic [PCW-1:0] pc;
    logic           taken;
    logic [PCW-1:0] target;
  } entry_t;

  entry_t          mem [DEPTH];
  entry_t          head_e_c;
  logic [PTRW-1:0] head_q, tail_q, head_nxt_c, tail_nxt_c, occ_nxt_c;
  logic            empty_c, res_ok_c, mis_c, push_ok_c;
  logic [PCW-1:0]  redir_c;

  // Resolve/mispredict evaluation and next-pointer computation
  always_comb begin
    empty_c    = (head_q == tail_q);
    res_ok_c   = resolve_i && !empty_c;
    head_e_c   = mem[head_q[QAW-1:0]];
    mis_c      = 1'b0;
    redir_c    = resolve_taken_i ? resolve_target_i : head_e_c.pc + PCW'(FALL_INC);
    if (res_ok_c) begin
      mis_c = (head_e_c.taken != resolve_taken_i) ||
              (head_e_c.taken && resolve_taken_i && (head_e_c.target != resolve_target_i));
    end
    push_ok_c  = push_i && !full_o && !mispredict_o && !mis_c;
    head_nxt_c = head_q + PTRW'(res_ok_c);
    tail_nxt_c = tail_q + PTRW'(push_ok_c);
    // Squash everything younger than the mispredicted branch, including this cycle's push
    if (mis_c) begin
      head_nxt_c = tail_q;
      tail_nxt_c = tail_q;
    end
    occ_nxt_c = tail_nxt_c - head_nxt_c;
  end

  always_ff @(posedge clk) begin
    if (push_ok_c) begin
      mem[tail_q[QAW-1:0]] <= '{pc: push_pc_i, taken: push_taken_i, target: push_target_i};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q            <= '0;
      tail_q            <= '0;
      count_o           <= '0;
      full_o            <= 1'b0;
      feedback_valid_o  <= 1'b0;
      feedback_pc_o     <= '0;
      feedback_taken_o  <= 1'b0;
      feedback_target_o <= '0;
      mispredict_o      <= 1'b0;
      redirect_pc_o     <= '0;
    end else begin
      head_q           <= head_nxt_c;
      tail_q           <= tail_nxt_c;
      count_o          <= occ_nxt_c;
      full_o           <= (occ_nxt_c == PTRW'(DEPTH));
      feedback_valid_o <= res_ok_c;
      mispredict_o     <= mis_c;
      if (res_ok_c) begin
        feedback_pc_o     <= head_e_c.pc;
        feedback_taken_o  <= resolve_taken_i;
        feedback_target_o <= resolve_target_i;
        redirect_pc_o     <= redir_c;
      end
    end
  end

`ifdef BPQ_STATS_EN
  // Saturating resolve / mispredict counters
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_branches_o <= '0;
      stat_mispred_o  <= '0;
    end else begin
      if (res_ok_c && (stat_branches_o != 16'hFFFF)) stat_branches_o <= stat_branches_o + 16'd1;
      if (mis_c && (stat_mispred_o != 16'hFFFF))     stat_mispred_o  <= stat_mispred_o + 16'd1;
    end
  end
`endif

endmodule
